// File: rtl/barrel_shift_arbiter.sv
// Two-requester round-robin front end for an external 8-bit barrel shifter.
// Each job is accepted in IDLE, shifted in SHIFT and held in RESP until consumed.
module barrel_shift_arbiter #(
  parameter int DATA_W = 8,
  parameter int AMT_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  input  logic [AMT_W-1:0]  req0_amt,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  input  logic [AMT_W-1:0]  req1_amt,
  output logic              req1_ready,
  output logic [DATA_W-1:0] sh_in,
  output logic [AMT_W-1:0]  sh_ctrl,
  input  logic [DATA_W-1:0] sh_out,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_id,
  input  logic              rsp_ready,
  output logic              busy,
  output logic [7:0]        op_count
);

  typedef enum logic [1:0] {IDLE, SHIFT, RESP} state_t;

  state_t              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic [DATA_W-1:0]   sh_in_q, sh_in_d;
  logic [AMT_W-1:0]    sh_ctrl_q, sh_ctrl_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                rsp_id_q, rsp_id_d;
  logic [7:0]          op_count_q, op_count_d;
  logic                grant;
  logic                accept;

  always_comb begin
    grant        = 1'b0;
    accept       = 1'b0;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    state_d      = state_q;
    last_grant_d = last_grant_q;
    sh_in_d      = sh_in_q;
    sh_ctrl_d    = sh_ctrl_q;
    rsp_data_d   = rsp_data_q;
    rsp_id_d     = rsp_id_q;
    op_count_d   = op_count_q;

    // On contention the requester that lost last time wins now.
    if (req0_valid && req1_valid) begin
      grant = ~last_grant_q;
    end else if (req1_valid) begin
      grant = 1'b1;
    end

    accept     = (state_q == IDLE) && !rst && (req0_valid || req1_valid);
    req0_ready = accept && !grant;
    req1_ready = accept && grant;

    case (state_q)
      IDLE: begin
        if (accept) begin
          sh_in_d      = grant ? req1_data : req0_data;
          sh_ctrl_d    = grant ? req1_amt  : req0_amt;
          rsp_id_d     = grant;
          last_grant_d = grant;
          state_d      = SHIFT;
        end
      end
      SHIFT: begin
        rsp_data_d = sh_out;
        state_d    = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          op_count_d = op_count_q + 8'd1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      sh_in_q      <= '0;
      sh_ctrl_q    <= '0;
      rsp_data_q   <= '0;
      rsp_id_q     <= 1'b0;
      op_count_q   <= 8'd0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      sh_in_q      <= sh_in_d;
      sh_ctrl_q    <= sh_ctrl_d;
      rsp_data_q   <= rsp_data_d;
      rsp_id_q     <= rsp_id_d;
      op_count_q   <= op_count_d;
    end
  end

  assign sh_in     = sh_in_q;
  assign sh_ctrl   = sh_ctrl_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign op_count  = op_count_q;
  assign rsp_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_barrel_shift_arbiter.sv
// Directed and randomized checks of barrel_shift_arbiter with a logical left-shift
// model standing in for the external shifter.
module tb_barrel_shift_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [7:0] req0_data = 8'd0, req1_data = 8'd0;
  logic [2:0] req0_amt = 3'd0, req1_amt = 3'd0;
  logic       req0_ready, req1_ready;
  logic [7:0] sh_in;
  logic [2:0] sh_ctrl;
  logic [7:0] sh_out;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_id;
  logic       rsp_ready = 1'b0;
  logic       busy;
  logic [7:0] op_count;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  assign sh_out = sh_in << sh_ctrl;

  barrel_shift_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_amt(req0_amt), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_amt(req1_amt), .req1_ready(req1_ready),
    .sh_in(sh_in), .sh_ctrl(sh_ctrl), .sh_out(sh_out),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_ready(rsp_ready),
    .busy(busy), .op_count(op_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req0_valid = 1'b1; req0_data = 8'hAA; req0_amt = 3'd2;
    req1_valid = 1'b1; rsp_ready = 1'b1;
    step();
    step();
    #1;
    vectors++; if ({req0_ready, req1_ready} !== 2'b00) begin miscompares++; $display("FAIL reset_ready: got %b want 00", {req0_ready, req1_ready}); end
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (op_count !== 8'd0) begin miscompares++; $display("FAIL reset_op_count: got %h want 00", op_count); end
    vectors++; if ({sh_in, sh_ctrl} !== 11'd0) begin miscompares++; $display("FAIL reset_sh: got %h/%h want 0/0", sh_in, sh_ctrl); end
    vectors++; if ({rsp_data, rsp_id} !== 9'd0) begin miscompares++; $display("FAIL reset_rsp: got %h/%b want 0/0", rsp_data, rsp_id); end
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    apply_reset();
    req0_valid = 1'b1; req0_data = 8'h81; req0_amt = 3'd1; rsp_ready = 1'b0;
    #1;
    vectors++; if ({req0_ready, req1_ready} !== 2'b10) begin miscompares++; $display("FAIL single_ready: got %b want 10", {req0_ready, req1_ready}); end
    step();
    req0_valid = 1'b0;
    #1;
    vectors++; if ({req0_ready, rsp_valid, busy} !== 3'b001) begin miscompares++; $display("FAIL single_shift: got rdy/vld/busy %b want 001", {req0_ready, rsp_valid, busy}); end
    vectors++; if ({sh_in, sh_ctrl} !== {8'h81, 3'd1}) begin miscompares++; $display("FAIL single_latch: got %h/%h want 81/1", sh_in, sh_ctrl); end
    step();
    vectors++; if ({rsp_valid, rsp_data, rsp_id} !== {1'b1, 8'h02, 1'b0}) begin miscompares++; $display("FAIL single_rsp: got %b/%h/%b want 1/02/0", rsp_valid, rsp_data, rsp_id); end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    vectors++; if ({op_count, rsp_valid, busy} !== {8'd1, 2'b00}) begin miscompares++; $display("FAIL single_done: got cnt %h vld %b busy %b want 01 0 0", op_count, rsp_valid, busy); end
  endtask

  task automatic test_contention();
    logic       exp_id;
    logic [7:0] exp_d;
    apply_reset();
    req0_valid = 1'b1; req0_data = 8'h80; req0_amt = 3'd0;
    req1_valid = 1'b1; req1_data = 8'h0F; req1_amt = 3'd4;
    rsp_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      exp_id = (j % 2 == 1);
      exp_d  = exp_id ? 8'hF0 : 8'h80;
      #1;
      vectors++; if ({req1_ready, req0_ready} !== {exp_id, ~exp_id}) begin miscompares++; $display("FAIL contention_grant%0d: got r1r0 %b want %b", j, {req1_ready, req0_ready}, {exp_id, ~exp_id}); end
      step();
      vectors++; if ({req0_ready, req1_ready} !== 2'b00) begin miscompares++; $display("FAIL contention_shift_ready%0d: got %b want 00", j, {req0_ready, req1_ready}); end
      step();
      vectors++; if ({rsp_valid, rsp_data, rsp_id} !== {1'b1, exp_d, exp_id}) begin miscompares++; $display("FAIL contention_rsp%0d: got %b/%h/%b want 1/%h/%b", j, rsp_valid, rsp_data, rsp_id, exp_d, exp_id); end
      step();
    end
    vectors++; if (op_count !== 8'd4) begin miscompares++; $display("FAIL contention_count: got %h want 04", op_count); end
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    apply_reset();
    req1_valid = 1'b1; req1_data = 8'h3C; req1_amt = 3'd2; rsp_ready = 1'b0;
    step();
    req1_valid = 1'b0;
    step();
    req0_valid = 1'b1; req0_data = 8'h11; req0_amt = 3'd1;
    for (int c = 0; c < 5; c++) begin
      #1;
      vectors++; if ({rsp_valid, rsp_data, rsp_id, busy} !== {1'b1, 8'hF0, 1'b1, 1'b1}) begin miscompares++; $display("FAIL backpressure_hold%0d: got vld %b data %h id %b busy %b want 1 f0 1 1", c, rsp_valid, rsp_data, rsp_id, busy); end
      vectors++; if ({req0_ready, req1_ready} !== 2'b00) begin miscompares++; $display("FAIL backpressure_ready%0d: got %b want 00", c, {req0_ready, req1_ready}); end
      step();
    end
    req0_valid = 1'b0;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    vectors++; if ({op_count, busy} !== {8'd1, 1'b0}) begin miscompares++; $display("FAIL backpressure_release: got cnt %h busy %b want 01 0", op_count, busy); end
  endtask

  task automatic test_boundary();
    logic [7:0] tab_d [2] = '{8'hFF, 8'hFF};
    logic [2:0] tab_a [2] = '{3'd7, 3'd0};
    logic [7:0] tab_e [2] = '{8'h80, 8'hFF};
    apply_reset();
    rsp_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      req0_valid = 1'b1; req0_data = tab_d[k]; req0_amt = tab_a[k];
      step();
      req0_valid = 1'b0;
      step();
      vectors++; if ({rsp_valid, rsp_data} !== {1'b1, tab_e[k]}) begin miscompares++; $display("FAIL boundary_amt%0d: got %b/%h want 1/%h", tab_a[k], rsp_valid, rsp_data, tab_e[k]); end
      step();
    end
    rsp_ready = 1'b0;
  endtask

  task automatic test_wrap();
    logic [7:0] d;
    logic [2:0] a;
    logic [7:0] e;
    apply_reset();
    rsp_ready = 1'b1;
    for (int n = 0; n < 256; n++) begin
      d = 8'($urandom_range(0, 255));
      a = 3'($urandom_range(0, 7));
      e = d << a;
      req0_valid = 1'b1; req0_data = d; req0_amt = a;
      step();
      req0_valid = 1'b0;
      step();
      if (n % 32 == 0) begin
        vectors++; if (rsp_data !== e) begin miscompares++; $display("FAIL wrap_data%0d: got %h want %h", n, rsp_data, e); end
      end
      step();
      if (n == 254) begin
        vectors++; if (op_count !== 8'd255) begin miscompares++; $display("FAIL wrap_255: got %h want ff", op_count); end
      end
    end
    rsp_ready = 1'b0;
    vectors++; if (op_count !== 8'd0) begin miscompares++; $display("FAIL wrap_zero: got %h want 00", op_count); end
  endtask

  task automatic test_reset_in_shift();
    apply_reset();
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_data = 8'h55; req0_amt = 3'd3;
    step();
    req0_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    vectors++; if ({rsp_valid, busy, op_count} !== 10'd0) begin miscompares++; $display("FAIL rst_shift_abort: got vld %b busy %b cnt %h want 0 0 00", rsp_valid, busy, op_count); end
    step();
    vectors++; if ({rsp_valid, op_count} !== 9'd0) begin miscompares++; $display("FAIL rst_shift_norsp: got vld %b cnt %h want 0 00", rsp_valid, op_count); end
    req1_valid = 1'b1; req1_data = 8'h09; req1_amt = 3'd1;
    #1;
    vectors++; if ({req0_ready, req1_ready} !== 2'b01) begin miscompares++; $display("FAIL rst_shift_regrant: got %b want 01", {req0_ready, req1_ready}); end
    step();
    req1_valid = 1'b0;
    step();
    vectors++; if ({rsp_valid, rsp_data, rsp_id} !== {1'b1, 8'h12, 1'b1}) begin miscompares++; $display("FAIL rst_shift_job: got %b/%h/%b want 1/12/1", rsp_valid, rsp_data, rsp_id); end
    step();
    rsp_ready = 1'b0;
    vectors++; if (op_count !== 8'd1) begin miscompares++; $display("FAIL rst_shift_count: got %h want 01", op_count); end
  endtask

  // Transaction-level reference: who may be granted, what the result must be,
  // and how many jobs have been consumed.
  task automatic test_random();
    int         phase;
    logic       last, win, er0, er1, exp_id;
    logic [7:0] cnt, exp_d, d0, d1;
    logic [2:0] a0, a1;
    logic       v0, v1;
    apply_reset();
    phase = 0; last = 1'b1; cnt = 8'd0; exp_d = 8'd0; exp_id = 1'b0;
    v0 = 1'b0; v1 = 1'b0; d0 = 8'd0; d1 = 8'd0; a0 = 3'd0; a1 = 3'd0;
    for (int c = 0; c < 3000; c++) begin
      if (!v0) begin
        v0 = ($urandom_range(0, 2) != 0); d0 = 8'($urandom_range(0, 255)); a0 = 3'($urandom_range(0, 7));
      end else if ($urandom_range(0, 9) == 0) v0 = 1'b0;
      if (!v1) begin
        v1 = ($urandom_range(0, 2) != 0); d1 = 8'($urandom_range(0, 255)); a1 = 3'($urandom_range(0, 7));
      end else if ($urandom_range(0, 9) == 0) v1 = 1'b0;
      req0_valid = v0; req0_data = d0; req0_amt = a0;
      req1_valid = v1; req1_data = d1; req1_amt = a1;
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      win = (v0 && v1) ? ~last : v1;
      er0 = (phase == 0) && v0 && !win;
      er1 = (phase == 0) && v1 && win;
      vectors++; if ({req0_ready, req1_ready} !== {er0, er1}) begin miscompares++; $display("FAIL rand_ready@%0d: got %b want %b", c, {req0_ready, req1_ready}, {er0, er1}); end
      vectors++; if ({rsp_valid, busy} !== {phase == 2, phase != 0}) begin miscompares++; $display("FAIL rand_status@%0d: got vld/busy %b want %b", c, {rsp_valid, busy}, {phase == 2, phase != 0}); end
      vectors++; if (op_count !== cnt) begin miscompares++; $display("FAIL rand_count@%0d: got %h want %h", c, op_count, cnt); end
      if (phase == 2) begin
        vectors++; if ({rsp_data, rsp_id} !== {exp_d, exp_id}) begin miscompares++; $display("FAIL rand_rsp@%0d: got %h/%b want %h/%b", c, rsp_data, rsp_id, exp_d, exp_id); end
      end
      if (er0 || er1) begin
        exp_d = win ? (d1 << a1) : (d0 << a0);
        exp_id = win; last = win; phase = 1;
        if (win) v1 = 1'b0; else v0 = 1'b0;
      end else if (phase == 1) begin
        phase = 2;
      end else if (phase == 2 && rsp_ready) begin
        cnt = cnt + 8'd1; phase = 0;
      end
      step();
    end
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_boundary();
    test_wrap();
    test_reset_in_shift();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/barrel_shift_arbiter.md
BARREL_SHIFT_ARBITER -- requirements
Module: barrel_shift_arbiter

Interface
REQ-001 The block SHALL have the port `clk`: input, 1 bit, sole clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port `rst`: input, 1 bit, synchronous, active-high reset.
REQ-003 The block SHALL have the port `req0_valid`: input, 1 bit, requester 0 has a shift job.
REQ-004 The block SHALL have the port `req0_data`: input, 8 bits, requester 0 operand.
REQ-005 The block SHALL have the port `req0_amt`: input, 3 bits, requester 0 shift amount.
REQ-006 The block SHALL have the port `req0_ready`: output, 1 bit, job accepted from requester 0 this cycle.
REQ-007 The block SHALL have the ports `req1_valid`, `req1_data`, `req1_amt`, `req1_ready`: same directions, widths and meanings as the requester 0 ports, for requester 1.
REQ-008 The block SHALL have the port `sh_in`: output, 8 bits, operand driven to the external barrel_shifter_8bit `in`.
REQ-009 The block SHALL have the port `sh_ctrl`: output, 3 bits, amount driven to the external shifter `ctrl`.
REQ-010 The block SHALL have the port `sh_out`: input, 8 bits, combinational result from the external shifter `out`.
REQ-011 The block SHALL have the port `rsp_valid`: output, 1 bit, result available.
REQ-012 The block SHALL have the port `rsp_data`: output, 8 bits, registered shifter result.
REQ-013 The block SHALL have the port `rsp_id`: output, 1 bit, index of the requester that owns `rsp_data`.
REQ-014 The block SHALL have the port `rsp_ready`: input, 1 bit, consumer accepts the result.
REQ-015 The block SHALL have the port `busy`: output, 1 bit, high whenever the state is not IDLE.
REQ-016 The block SHALL have the port `op_count`: output, 8 bits, number of completed jobs.

Function
REQ-017 The FSM SHALL have exactly three states, IDLE, SHIFT and RESP, and SHALL be in IDLE after reset.
REQ-018 In IDLE with at least one `reqN_valid` high, the block SHALL grant exactly one requester: if only one is valid it gets the grant; if both are valid, grant SHALL go to the requester not granted last (`last_grant` register).
REQ-019 `reqN_ready` SHALL be combinational and high only for the state==IDLE && `reqN_valid` && grant==N cycle; a job SHALL transfer on `valid & ready`.
REQ-020 On the transfer edge, the block SHALL latch data into `sh_in`, amt into `sh_ctrl` and N into `rsp_id`, update `last_grant` to N, and go to SHIFT.
REQ-021 In SHIFT (exactly 1 cycle), the block SHALL capture `sh_out` into `rsp_data` and go to RESP.
REQ-022 In RESP, `rsp_valid` SHALL be 1; on `rsp_valid & rsp_ready` the block SHALL increment `op_count` (modulo 256, 255 -> 0) and go to IDLE.
REQ-023 The block SHALL hold RESP indefinitely while `rsp_ready` is low, with `rsp_data`/`rsp_id` stable and both `reqN_ready` low.
REQ-024 Accept-to-`rsp_valid` latency SHALL be 2 cycles, with a minimum of 3 cycles per job (IDLE, SHIFT, RESP).
REQ-025 A `reqN_valid` deasserted before its grant SHALL be dropped without side effects; requesters SHALL hold data/amt stable while valid.
REQ-026 `sh_in` and `sh_ctrl` SHALL remain at their last latched values outside SHIFT.
REQ-027 An `rsp_ready` asserted outside RESP SHALL be ignored.

Reset
REQ-028 With `rst`=1 at a clock edge, the block SHALL go to state IDLE and set `last_grant`=1 (so requester 0 wins first), `sh_in`=0, `sh_ctrl`=0, `rsp_data`=0, `rsp_id`=0, `rsp_valid`=0, `op_count`=0 and `busy`=0.
REQ-029 During reset, both `reqN_ready` SHALL be 0.
REQ-030 A reset asserted in SHIFT or RESP SHALL abort the job with no response and no `op_count` increment.

Verification (the bench models the shifter as `sh_out` = `sh_in` << `sh_ctrl`, logical)
REQ-031 Single job: after reset, req0 with 0x81, amt 1 -> `req0_ready` pulses 1 cycle, `rsp_valid` high 2 cycles later with `rsp_data`=0x02, `rsp_id`=0, and `op_count`=1 after the handshake.
REQ-032 Contention: both valid after reset (req0 0x80 amt 0, req1 0x0F amt 4) -> req0 is served first (`rsp_data`=0x80, `rsp_id`=0), then req1 (0xF0, `rsp_id`=1); with both held valid, the grant alternates 0,1,0,1.
REQ-033 Backpressure: `rsp_ready` low for 5 cycles in RESP -> `rsp_valid`, `rsp_data` and `rsp_id` stay stable, no `reqN_ready`, and `busy`=1 throughout.
REQ-034 Boundary amounts: 0xFF amt 7 -> 0x80; 0xFF amt 0 -> 0xFF.
REQ-035 Wrap: 256 completed jobs -> `op_count` returns to 0.
REQ-036 Reset in SHIFT -> next cycle `rsp_valid`=0, `busy`=0, `op_count` unchanged-reset to 0, and the next req1-only job is granted normally.
